// File: rtl/issue_ctrl_pkg.sv
// Shared opcodes, queue entry layout and FSM state type for the issue controller.
// Small helpers keep pointer sizing and load/store classification in one place.
package issue_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam int ENTRY_W = 64;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    // Pointer width for a power-of-two queue depth.
    function automatic int iq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic is_mem_op(input logic [31:0] instr);
        return (instr[6:0] == OPC_LOAD) || (instr[6:0] == OPC_STORE);
    endfunction

endpackage

// File: rtl/issue_ctrl_iq_fifo.sv
// Synchronous circular instruction queue with push/pop/clear and a combinational head read.
// Pointers wrap naturally because the depth is a power of two.
module iq_fifo
    import issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       clear,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         head_data,
    output logic [iq_ptr_w(DEPTH):0]   count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = iq_ptr_w(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               do_push;
    logic               do_pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full && !clear;
    assign do_pop    = pop && !empty && !clear;
    assign head_data = mem[head];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only ever
    // read below count, and leaving it reset-free lets it map onto RAM.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller: queues fetched (pc, instr) pairs and issues one per cycle to the
// decoder when the ROB and the target RS/LSB can accept it; handles flush and stall counting.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instr,
    output logic             if_ready,
    input  logic             rob_full,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             dec_valid,
    output logic [31:0]      dec_pc,
    output logic [31:0]      dec_instr,
    output logic             dec_is_mem,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int PTR_W = iq_ptr_w(IQ_DEPTH);

    state_t             state;
    state_t             state_next;
    iq_entry_t          push_entry;
    iq_entry_t          head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic [PTR_W:0]     iq_count;
    logic               iq_full;
    logic               iq_empty;
    logic               push;
    logic               issue;
    logic               head_is_mem;
    logic               res_ok;
    logic               stall_inc;

    assign push_entry = '{pc: if_pc, instr: if_instr};
    assign head_entry = iq_entry_t'(head_bits);

    iq_fifo #(
        .DEPTH (IQ_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear     (flush_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (issue),
        .head_data (head_bits),
        .count     (iq_count),
        .full      (iq_full),
        .empty     (iq_empty)
    );

    // Readiness looks at the current count only, so a full queue never
    // relies on a same-cycle pop to make room.
    assign if_ready    = (state == ST_RUN) && !iq_full;
    assign push        = if_valid && if_ready && rdy_in && !flush_in;
    assign head_is_mem = is_mem_op(head_entry.instr);

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        res_ok     = 1'b0;
        issue      = 1'b0;
        stall_inc  = 1'b0;

        if (flush_in) begin
            state_next = ST_FLUSH;
        end else if (rdy_in) begin
            state_next = ST_RUN;
        end

        res_ok = !rob_full && (head_is_mem ? !lsb_full : !rs_full);

        if ((state == ST_RUN) && !iq_empty && rdy_in && !flush_in) begin
            issue     = res_ok;
            stall_inc = !res_ok;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Payload registers hold their last value on idle cycles; only valid drops.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            dec_valid  <= 1'b0;
            dec_pc     <= '0;
            dec_instr  <= '0;
            dec_is_mem <= 1'b0;
        end else if (flush_in) begin
            dec_valid <= 1'b0;
        end else if (rdy_in) begin
            dec_valid <= issue;
            if (issue) begin
                dec_pc     <= head_entry.pc;
                dec_instr  <= head_entry.instr;
                dec_is_mem <= head_is_mem;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Sequences the instruction decoder.
- Buffers fetched (pc, instr) pairs in an instruction queue.
- Issues at most one instruction per cycle into the decoder, only when the downstream resources can accept it: ROB, and RS for ALU/branch/jump or LSB for load/store.
- Handles pipeline flush on mispredict and counts stall cycles.
- Sits between instruction fetch and decoder.

Parameters:
- IQ_DEPTH, 8, queue entries; power of two, at least 2.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- rdy_in  input  1  global ready; when low, pause all state
- flush_in  input  1  mispredict flush
- if_valid  input  1  fetch offers an instruction
- if_pc  input  32  fetched instruction pc
- if_instr  input  32  fetched instruction word
- if_ready  output  1  queue can accept (combinational)
- rob_full  input  1  ROB has no free entry
- rs_full  input  1  RS has no free entry
- lsb_full  input  1  LSB has no free entry
- dec_valid  output  1  registered; pc/instr below are valid this cycle
- dec_pc  output  32  pc to decoder
- dec_instr  output  32  instruction to decoder
- dec_is_mem  output  1  issued instruction is a load/store
- stall_cnt  output  CNT_W  saturating count of blocked-issue cycles

Behaviour:
- Reset (rst_in low at a rising edge):
  - Queue empty: head, tail and count all 0.
  - State is RUN.
  - dec_valid=0, dec_pc=0, dec_instr=0, dec_is_mem=0, stall_cnt=0.
  - Reset overrides flush_in and rdy_in.
- States:
  - RUN: normal operation.
  - FLUSH: lasts exactly one cycle; if_ready=0; no issue; dec_valid=0. Always returns to RUN.
- if_ready = (state==RUN) && (count < IQ_DEPTH). It depends on count only, so a full queue refuses a push even if a pop happens the same cycle.
- Push: if_valid && if_ready && rdy_in && !flush_in at the edge writes {if_pc, if_instr} at tail. Tail wraps modulo IQ_DEPTH.
- Head classification: head_is_mem = (opcode 7'b0000011) || (opcode 7'b0100011), using head instr[6:0].
- issue = RUN && count!=0 && rdy_in && !flush_in && !rob_full && (head_is_mem ? !lsb_full : !rs_full).
- When issue is true at an edge:
  - Head pops and wraps.
  - dec_valid<=1, dec_pc/dec_instr/dec_is_mem <= head fields.
- When issue is false and rdy_in is high: dec_valid<=0; dec_pc/dec_instr/dec_is_mem keep their values.
- Latency: push accepted at edge N; earliest dec_valid high after edge N+1. Sustained throughput is 1 instruction/cycle when unblocked.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- stall_cnt increments when RUN && rdy_in && count!=0 && !issue && !flush_in. It saturates at all-ones.
- rdy_in low: pointers, count, state, registered outputs and stall_cnt all hold. No push, no pop.
- flush_in high at an edge (with reset inactive):
  - Applies regardless of rdy_in.
  - Head=tail=count=0; dec_valid<=0; state<=FLUSH.
  - A same-cycle push is dropped and no issue occurs.
  - stall_cnt is not cleared.
- flush_in asserted while in FLUSH: stay in FLUSH one more cycle.
- Unknown opcodes are issued as non-mem (RS path); the decoder handles legality.

Decomposition:
- Shared constants go in defines.v: OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, and the IQ pointer width derived from IQ_DEPTH via $clog2.
- One sub-module, iq_fifo: a synchronous circular buffer with push/pop/clear, count, full and empty, and a combinational head read.
- issue_ctrl holds the FSM, the issue gating, the output registers and the stall counter.

Test Plan:
1. Reset, then push 3 instructions (pc 0x0,0x4,0x8; addi/lw/sw encodings), all full flags low -> dec_valid high for 3 consecutive cycles; first appears one cycle after its push edge; dec_is_mem sequence 0,1,1.
2. Fill 8 entries with rs_full=1 and all entries ALU -> if_ready=0 at count 8; 9th offer is not accepted; stall_cnt counts each blocked cycle. Release rs_full -> 8 issues back-to-back in pc order.
3. Head is lw with lsb_full=1 and rs_full=0 -> no issue (in-order). Deassert lsb_full -> lw issues, then the following add issues next cycle.
4. Queue holds 5 entries and flush_in is pulsed with if_valid high -> next cycle count=0, dec_valid=0, if_ready=0 (FLUSH). Following cycle if_ready=1; the pushed instruction was dropped.
5. rdy_in low for 4 cycles mid-stream -> dec_* registers, count and stall_cnt are frozen; the stream resumes with no duplicate or lost pc.
6. Preload stall_cnt to 0xFFFE (CNT_W=16) via a long block -> it reaches 0xFFFF and holds. rst_in low mid-stream -> all outputs 0 the next cycle.
